// File: rtl/uart_r.sv
// UART receiver: start bit, d_width data bits LSB first, one stop bit.
// The data word is registered; rx_valid and rx_err are single-cycle pulses.
module uart_r #(
  parameter int d_width      = 6,
  parameter int clks_per_bit = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [d_width-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_err,
  output logic               rx_busy
);

  localparam int CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int BIT_W = (d_width > 1) ? $clog2(d_width) : 1;
  localparam int HALF  = (clks_per_bit - 1) / 2;
  // The start edge already used one cycle, so a zero half-bit still resamples on the next edge
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(clks_per_bit - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(d_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [d_width-1:0] shift;
  logic               cnt_clr, bit_clr, bit_inc, shift_en, valid_set, err_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    bit_clr    = (state != DATA);
    bit_inc    = 1'b0;
    shift_en   = 1'b0;
    valid_set  = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx) state_next = (clks_per_bit == 1) ? DATA : START;
      end
      START: begin
        if (cnt == START_LAST) begin
          cnt_clr    = 1'b1;
          state_next = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_clr    = 1'b1;
            state_next = STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (rx) begin
            valid_set  = 1'b1;
            state_next = IDLE;
          end else begin
            err_set    = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rx) state_next = IDLE;
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + BIT_W'(1);
      // Shifting in from the top leaves the first received bit at the LSB
      if (shift_en)  shift   <= {rx, shift[d_width-1:1]};
      if (valid_set) rx_data <= shift;
      rx_valid <= valid_set;
      rx_err   <= err_set;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_r.sv
// Bench for uart_r: per-edge frame-level model for a 1 clk/bit receiver,
// plus directed and random frames for a 4 clk/bit receiver.
module tb_uart_r;

  localparam int D    = 6;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1, rx1, valid1, err1, busy1;
  logic         rst4, rx4, valid4, err4, busy4;
  logic [D-1:0] data1, data4;

  uart_r #(.d_width(D), .clks_per_bit(1)) dut1 (
    .clk(clk), .rst(rst1), .rx(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_err(err1), .rx_busy(busy1)
  );

  uart_r #(.d_width(D), .clks_per_bit(4)) dut4 (
    .clk(clk), .rst(rst4), .rx(rx4),
    .rx_data(data4), .rx_valid(valid4), .rx_err(err4), .rx_busy(busy4)
  );

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Expected outputs after each rising edge of dut1, filled in by the frame driver
  bit           exp_set   [MAXE];
  bit           exp_busy  [MAXE];
  bit           exp_valid [MAXE];
  bit           exp_err   [MAXE];
  logic [D-1:0] exp_data  [MAXE];
  logic [D-1:0] model_data;

  int valid_q[$];
  int err_pulses1 = 0;
  bit done4 = 1'b0;

  int           v4_cnt, e4_cnt;
  logic [D-1:0] v4_data, prev4;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_exp(input bit busy, input bit valid, input bit err);
    int e;
    e = edge_cnt + 1;
    if (e < MAXE) begin
      exp_set[e]   = 1'b1;
      exp_busy[e]  = busy;
      exp_valid[e] = valid;
      exp_err[e]   = err;
      exp_data[e]  = model_data;
    end
  endtask

  task automatic apply_stimulus(input logic b, input bit busy, input bit valid, input bit err);
    @(negedge clk);
    rx1 = b;
    set_exp(busy, valid, err);
  endtask

  task automatic send_body(input logic [D-1:0] d, input bit stop_ok, input int hold0);
    for (int i = 0; i < D; i++) apply_stimulus(d[i], 1'b1, 1'b0, 1'b0);
    if (stop_ok) begin
      model_data = d;
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (hold0) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [D-1:0] d, input bit stop_ok, input int hold0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    send_body(d, stop_ok, hold0);
  endtask

  task automatic hold4(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      rx4 = b;
      @(posedge clk);
      #1;
      if (valid4) begin
        v4_cnt++;
        v4_data = data4;
      end
      if (err4) e4_cnt++;
    end
  endtask

  task automatic frame4(input logic [D-1:0] d, input logic stop);
    v4_cnt = 0;
    e4_cnt = 0;
    hold4(1'b0, 4);
    for (int i = 0; i < D; i++) hold4(d[i], 4);
    hold4(stop, 4);
    hold4(1'b1, 2);
    check_output("cpb4_valid_count", 32'(v4_cnt), stop ? 32'd1 : 32'd0);
    check_output("cpb4_err_count",   32'(e4_cnt), stop ? 32'd0 : 32'd1);
    check_output("cpb4_data",        32'(data4),  stop ? 32'(d) : 32'(prev4));
    check_output("cpb4_busy_after",  32'(busy4),  32'd0);
    if (stop) prev4 = d;
  endtask

  // Per-edge comparison of dut1 against the frame model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (edge_cnt < MAXE && exp_set[edge_cnt]) begin
        check_output("valid1", 32'(valid1), 32'(exp_valid[edge_cnt]));
        check_output("err1",   32'(err1),   32'(exp_err[edge_cnt]));
        check_output("busy1",  32'(busy1),  32'(exp_busy[edge_cnt]));
        check_output("data1",  32'(data1),  32'(exp_data[edge_cnt]));
      end
      if (valid1) valid_q.push_back(edge_cnt);
      if (err1) err_pulses1++;
    end
  end

  // 4 clk/bit receiver: false start, directed frame, error frame, random frames
  initial begin
    rst4 = 1'b1;
    rx4  = 1'b1;
    prev4 = '0;
    #1 rst4 = 1'b0;
    @(negedge clk);
    check_output("cpb4_reset_data",  32'(data4),  32'd0);
    check_output("cpb4_reset_valid", 32'(valid4), 32'd0);
    check_output("cpb4_reset_busy",  32'(busy4),  32'd0);
    @(negedge clk);
    rst4 = 1'b1;
    hold4(1'b1, 3);
    v4_cnt = 0;
    e4_cnt = 0;
    hold4(1'b0, 1);
    check_output("cpb4_start_busy", 32'(busy4), 32'd1);
    hold4(1'b1, 12);
    check_output("cpb4_false_valid", 32'(v4_cnt), 32'd0);
    check_output("cpb4_false_err",   32'(e4_cnt), 32'd0);
    check_output("cpb4_false_busy",  32'(busy4),  32'd0);
    frame4(6'h2A, 1'b1);
    check_output("cpb4_data_2a", 32'(data4), 32'h2A);
    frame4(6'h15, 1'b0);
    for (int i = 0; i < 6; i++) begin
      hold4(1'b1, $urandom_range(0, 5));
      frame4(D'($urandom), 1'b1);
    end
    done4 = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n_before;
    logic [D-1:0] rd;
    rst1 = 1'b1;
    rx1  = 1'b1;
    model_data = '0;
    #1 rst1 = 1'b0;
    @(negedge clk);
    check_output("reset_data",  32'(data1),  32'd0);
    check_output("reset_valid", 32'(valid1), 32'd0);
    check_output("reset_err",   32'(err1),   32'd0);
    check_output("reset_busy",  32'(busy1),  32'd0);
    @(negedge clk);
    rst1 = 1'b1;
    rx1  = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    send_frame(6'h2D, 1'b1, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("frame_2d_valid", 32'(valid1), 32'd1);
    check_output("frame_2d_data",  32'(data1),  32'h2D);
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    n_before = err_pulses1;
    send_frame(6'h2D, 1'b0, 3);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("frame_err_pulses", 32'(err_pulses1 - n_before), 32'd1);
    check_output("frame_err_data",   32'(data1), 32'h2D);

    send_frame(6'h3F, 1'b1, 0);
    send_frame(6'h00, 1'b1, 0);
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("b2b_spacing", 32'(valid_q[$] - valid_q[$-1]), 32'd8);
    check_output("b2b_data",    32'(data1), 32'h00);

    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(0, 3)) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(D'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(0, 3));
    end
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame, after data bits 0..2
    rd = 6'h2A;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(rd[i], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst1 = 1'b0;
    rx1  = 1'b1;
    model_data = '0;
    set_exp(1'b0, 1'b0, 1'b0);
    #1;
    check_output("midreset_data",  32'(data1),  32'd0);
    check_output("midreset_valid", 32'(valid1), 32'd0);
    check_output("midreset_err",   32'(err1),   32'd0);
    check_output("midreset_busy",  32'(busy1),  32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst1 = 1'b1;
    rx1  = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    repeat (6) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Start bit on the very first edge after reset release, transmitter word 0x15
    @(negedge clk);
    rst1 = 1'b0;
    rx1  = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    n_before = valid_q.size();
    @(negedge clk);
    rst1 = 1'b1;
    rx1  = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    send_body(6'h15, 1'b1, 0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("tx_frame_data",   32'(data1), 32'h15);
    check_output("tx_frame_pulses", 32'(valid_q.size() - n_before), 32'd1);

    while (!done4) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
